// File: rtl/sort_stream_unloader_if.sv
// Handshake bundle between the final sort stage, the unloader and the
// downstream element consumer.
interface sort_stream_unloader_if #(
  parameter int width = 8,
  parameter int index = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [width-1:0]          in_data [0:index-1];
  logic                      out_valid;
  logic                      out_ready;
  logic [width-1:0]          out_data;
  logic [$clog2(index)-1:0]  out_index;
  logic                      out_last;

  // slave: the unloader itself; master: the surrounding pipeline/consumer
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/sort_stream_unloader.sv
// Captures one sorted parallel vector and replays it as a framed element
// stream, one beat per accepted out handshake.
module sort_stream_unloader #(
  parameter int width      = 8,
  parameter int index      = 8,
  parameter int descending = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sort_stream_unloader_if.slave bus
);
  localparam int IW = $clog2(index);
  localparam logic [IW-1:0] LAST = IW'(index - 1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]    cnt, k_nxt, p_first, p_nxt;
  logic [width-1:0] buffer [0:index-1];
  logic             capture, beat;

  function automatic logic [IW-1:0] beat_pos(input logic [IW-1:0] k);
    return (descending != 0) ? LAST - k : k;
  endfunction

  assign bus.out_valid = (state == SEND);
  // Ready again on the edge the final beat leaves, giving zero-bubble frames
  assign bus.in_ready  = !rst && ((state == IDLE) ||
                                  (bus.out_valid && bus.out_ready && bus.out_last));
  assign capture = bus.in_valid && bus.in_ready;
  assign beat    = bus.out_valid && bus.out_ready;
  assign k_nxt   = cnt + 1'b1;
  assign p_first = beat_pos('0);
  assign p_nxt   = beat_pos(k_nxt);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = SEND;
      SEND: begin
        if (capture)                     state_nxt = SEND;
        else if (beat && bus.out_last)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      for (int i = 0; i < index; i++) buffer[i] <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        for (int i = 0; i < index; i++) buffer[i] <= bus.in_data[i];
        cnt           <= '0;
        bus.out_data  <= bus.in_data[p_first];
        bus.out_index <= p_first;
        bus.out_last  <= 1'b0;
      end else if (beat && !bus.out_last) begin
        cnt           <= k_nxt;
        bus.out_data  <= buffer[p_nxt];
        bus.out_index <= p_nxt;
        bus.out_last  <= (k_nxt == LAST);
      end
    end
  end
endmodule

// File: tb/tb_sort_stream_unloader.sv
// Directed bench: ascending and descending unloaders, back-pressure,
// back-to-back frames, mid-frame reset and ignored input.
module tb_sort_stream_unloader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_stream_unloader_if #(.width(8), .index(8)) ia ();
  sort_stream_unloader_if #(.width(8), .index(8)) id ();

  sort_stream_unloader #(.width(8), .index(8), .descending(0)) u_asc (
    .clk(clk), .rst(rst), .bus(ia)
  );
  sort_stream_unloader #(.width(8), .index(8), .descending(1)) u_dsc (
    .clk(clk), .rst(rst), .bus(id)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vv [0:7];
  logic [7:0] ww [0:7];
  logic [7:0] cc [0:7];

  task automatic load_a(input logic [7:0] v [0:7]);
    for (int i = 0; i < 8; i++) ia.in_data[i] = v[i];
  endtask

  initial begin
    int beats;
    vv = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd20, 8'd33, 8'd40, 8'd99};
    ww = '{8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57};
    cc = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207};
    ia.in_valid = 0; ia.out_ready = 0;
    id.in_valid = 0; id.out_ready = 0;
    for (int i = 0; i < 8; i++) begin ia.in_data[i] = '0; id.in_data[i] = '0; end

    // reset state
    tick(); tick();
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_data",  ia.out_data, 0);
    chk("rst_index", ia.out_index, 0);
    chk("rst_last",  ia.out_last, 0);
    chk("rst_ready", ia.in_ready, 0);
    rst = 0; #1;
    chk("idle_ready", ia.in_ready, 1);

    // basic ascending + descending in parallel
    load_a(vv);
    for (int i = 0; i < 8; i++) id.in_data[i] = vv[i];
    ia.in_valid = 1; id.in_valid = 1; ia.out_ready = 1; id.out_ready = 1;
    tick();
    ia.in_valid = 0; id.in_valid = 0;
    for (int k = 0; k < 8; k++) begin
      chk("asc_valid", ia.out_valid, 1);
      chk("asc_data",  ia.out_data, vv[k]);
      chk("asc_index", ia.out_index, k);
      chk("asc_last",  ia.out_last, k == 7);
      chk("asc_inrdy", ia.in_ready, k == 7);
      chk("dsc_data",  id.out_data, vv[7-k]);
      chk("dsc_index", id.out_index, 7 - k);
      chk("dsc_last",  id.out_last, k == 7);
      tick();
    end
    chk("asc_done", ia.out_valid, 0);
    chk("dsc_done", id.out_valid, 0);

    // back-pressure at beat 2
    ia.in_valid = 1; tick(); ia.in_valid = 0;
    beats = 0;
    for (int k = 0; k < 2; k++) begin
      chk("bp_pre", ia.out_data, vv[k]);
      if (ia.out_valid && ia.out_ready) beats++;
      tick();
    end
    ia.out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      chk("bp_hold_valid", ia.out_valid, 1);
      chk("bp_hold_data",  ia.out_data, 9);
      chk("bp_hold_index", ia.out_index, 2);
      tick();
    end
    ia.out_ready = 1;
    for (int k = 2; k < 8; k++) begin
      chk("bp_post", ia.out_data, vv[k]);
      if (ia.out_valid && ia.out_ready) beats++;
      tick();
    end
    chk("bp_beats", beats, 8);
    chk("bp_done", ia.out_valid, 0);

    // back-to-back: A = 0..7 then B = 8..15
    for (int i = 0; i < 8; i++) ia.in_data[i] = 8'(i);
    ia.in_valid = 1; tick();
    for (int i = 0; i < 8; i++) ia.in_data[i] = 8'(i + 8);
    for (int k = 0; k < 16; k++) begin
      chk("b2b_valid", ia.out_valid, 1);
      chk("b2b_data",  ia.out_data, k);
      chk("b2b_last",  ia.out_last, (k % 8) == 7);
      if (k == 7) chk("b2b_swap_ready", ia.in_ready, 1);
      if (k == 15) ia.in_valid = 0;
      tick();
    end
    chk("b2b_done", ia.out_valid, 0);

    // reset after beat 3 accepted
    load_a(vv); ia.in_valid = 1; tick(); ia.in_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_beat4", ia.out_data, vv[4]);
    rst = 1; tick();
    chk("mr_valid", ia.out_valid, 0);
    chk("mr_data",  ia.out_data, 0);
    chk("mr_index", ia.out_index, 0);
    chk("mr_last",  ia.out_last, 0);
    chk("mr_ready_in_rst", ia.in_ready, 0);
    rst = 0; #1;
    chk("mr_ready", ia.in_ready, 1);
    load_a(ww); ia.in_valid = 1; tick(); ia.in_valid = 0;
    chk("mr_fresh_data",  ia.out_data, 50);
    chk("mr_fresh_index", ia.out_index, 0);
    for (int k = 0; k < 8; k++) tick();
    chk("mr_fresh_done", ia.out_valid, 0);

    // in_valid during beat 4 is ignored
    load_a(vv); ia.in_valid = 1; tick(); ia.in_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    load_a(cc); ia.in_valid = 1;
    #1 chk("ign_ready", ia.in_ready, 0);
    tick(); ia.in_valid = 0;
    for (int k = 5; k < 8; k++) begin
      chk("ign_data", ia.out_data, vv[k]);
      chk("ign_last", ia.out_last, k == 7);
      tick();
    end
    chk("ign_done", ia.out_valid, 0);
    tick();
    chk("ign_stay_idle", ia.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
